// File: rtl/kernel_host_pkg.sv
// Shared types for the kernel host: FSM states and the queued job record.
package kernel_host_pkg;
  localparam int N_W = 6;
  localparam int D_W = 32;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} host_state_t;

  typedef struct packed {
    logic [N_W-1:0] n;
    logic [D_W-1:0] a;
    logic [D_W-1:0] b;
  } job_t;
endpackage

// File: rtl/job_fifo.sv
// Pointer-plus-count job FIFO; a full FIFO refuses a push even while popping.
module job_fifo
  import kernel_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  job_t din,
  output logic full,
  output logic empty,
  output job_t head
);
  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/kernel_host.sv
// Queues argument jobs, launches them one at a time on a start/done kernel,
// and returns each result (or timeout) on a valid/ready response stream.
module kernel_host
  import kernel_host_pkg::*;
#(
  parameter int N_WIDTH    = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [N_WIDTH-1:0]    req_n,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_timeout,
  output logic                  k_r_enable,
  output logic [N_WIDTH-1:0]    k_init_n,
  output logic [DATA_WIDTH-1:0] k_init_a,
  output logic [DATA_WIDTH-1:0] k_init_b,
  input  logic                  k_w_enable,
  input  logic [DATA_WIDTH-1:0] k_result,
  output logic                  busy,
  output logic [15:0]           jobs_done
);
  localparam int CW = $clog2(TIMEOUT);

  host_state_t   state, state_nx;
  logic [CW-1:0] tcnt;
  logic          full, empty, pop;
  logic          done_ok, tmo;
  job_t          din, head;

  assign din       = {req_n, req_a, req_b};
  assign req_ready = !full;

  job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // tcnt==0 marks the first WAIT cycle, where done may still be stale.
  assign done_ok = (tcnt != '0) && k_w_enable;
  assign tmo     = (tcnt == CW'(TIMEOUT-1));

  assign k_r_enable = (state == LAUNCH);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:   if (!empty) begin
                pop      = 1'b1;
                state_nx = LAUNCH;
              end
      LAUNCH: state_nx = WAIT;
      WAIT:   if (done_ok || tmo) state_nx = RESP;
      RESP:   if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_init_n     <= '0;
      k_init_a     <= '0;
      k_init_b     <= '0;
      tcnt         <= '0;
      resp_result  <= '0;
      resp_timeout <= 1'b0;
      jobs_done    <= '0;
    end else begin
      if (pop) begin
        k_init_n <= head.n;
        k_init_a <= head.a;
        k_init_b <= head.b;
      end
      if (state == LAUNCH)    tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;
      // Completion takes priority over a timeout landing in the same cycle.
      if (state == WAIT) begin
        if (done_ok) begin
          resp_result  <= k_result;
          resp_timeout <= 1'b0;
        end else if (tmo) begin
          resp_result  <= '0;
          resp_timeout <= 1'b1;
        end
      end
      if (resp_valid && resp_ready) jobs_done <= jobs_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_kernel_host.sv
// Randomized bench for kernel_host with a behavioural kernel and a
// job-level reference model of queueing, timing and responses.
module tb_kernel_host;
  localparam int NW = 6, DW = 32, DEPTH = 4, TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] req_n = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_result;
  logic          resp_timeout;
  logic          k_r_enable;
  logic [NW-1:0] k_init_n;
  logic [DW-1:0] k_init_a, k_init_b;
  logic          k_w_enable = 1'b1;
  logic [DW-1:0] k_result = 32'hdead_beef;
  logic          busy;
  logic [15:0]   jobs_done;

  kernel_host #(.N_WIDTH(NW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_timeout(resp_timeout),
    .k_r_enable(k_r_enable), .k_init_n(k_init_n), .k_init_a(k_init_a), .k_init_b(k_init_b),
    .k_w_enable(k_w_enable), .k_result(k_result),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Kernel iterates (a,b) <- (b,a+b) n times and returns a.
  function automatic logic [31:0] fib(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a; y = b;
    for (int i = 0; i < int'(n); i++) begin
      t = x + y; x = y; y = t;
    end
    return x;
  endfunction

  typedef struct { logic [5:0] n; logic [31:0] a; logic [31:0] b; int d; } job_s;

  job_s        pend_q[$];
  job_s        k_job_next, kj;
  int          req_d = 1;
  int          cyc = 0, rise = 0, model_done = 0;
  bit          in_flight = 0, prev_kre = 0;
  logic [31:0] exp_res, last_res;
  logic        exp_to, last_to;
  int          load_seq = 0, seen_seq = 0, kcyc = 0;
  bit          kact = 0;
  int          rr_mode = 1;

  // Kernel: done/result stay stale for one cycle after load, then done
  // appears d cycles into WAIT (d large = never).
  always @(posedge clk) begin
    if (load_seq != seen_seq) begin
      seen_seq = load_seq;
      kj       = k_job_next;
      kact     = 1;
      kcyc     = 0;
    end else if (kact) begin
      kcyc++;
      if (kcyc >= kj.d) begin
        k_w_enable <= 1'b1;
        k_result   <= fib(kj.n, kj.a, kj.b);
      end else begin
        k_w_enable <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b0;
      1:       resp_ready = 1'b1;
      default: resp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    job_s j;
    cyc++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_result", resp_result, 0);
      chk("rst_resp_timeout", resp_timeout, 0);
      chk("rst_kre", k_r_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_jobs_done", jobs_done, 0);
      pend_q.delete();
      in_flight  = 0;
      model_done = 0;
      prev_kre   = 0;
    end else begin
      if (k_r_enable) begin
        chk("kre_one_cycle", prev_kre, 0);
        chk("launch_while_busy", in_flight, 0);
        chk("launch_has_job", pend_q.size() != 0, 1);
        if (pend_q.size() != 0) begin
          j = pend_q.pop_front();
          chk("k_init_n", k_init_n, j.n);
          chk("k_init_a", k_init_a, j.a);
          chk("k_init_b", k_init_b, j.b);
          in_flight  = 1;
          exp_to     = (j.d >= TMO);
          exp_res    = exp_to ? 32'd0 : fib(j.n, j.a, j.b);
          rise       = cyc + 2 + ((j.d < TMO-1) ? j.d : TMO-1);
          k_job_next = j;
          load_seq++;
        end
      end
      prev_kre = k_r_enable;
      chk("busy", busy, in_flight);
      chk("resp_valid", resp_valid, in_flight && (cyc >= rise));
      chk("jobs_done", jobs_done, 16'(model_done));
      if (resp_valid && in_flight) begin
        chk("resp_result", resp_result, exp_res);
        chk("resp_timeout", resp_timeout, exp_to);
      end
      if (resp_valid && resp_ready) begin
        model_done++;
        in_flight = 0;
        last_res  = resp_result;
        last_to   = resp_timeout;
      end
      chk("req_ready", req_ready, pend_q.size() < DEPTH);
      if (req_valid && req_ready)
        pend_q.push_back('{n:req_n, a:req_a, b:req_b, d:req_d});
    end
  end

  task automatic push_job(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b, input int d);
    int  budget = 300;
    bit  ok;
    req_n = n; req_a = a; req_b = b; req_d = d; req_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = req_ready;
      budget--;
      @(posedge clk); #1;
    end while (!ok && budget > 0);
    if (!ok) chk("push_accept", ok, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while ((pend_q.size() != 0 || in_flight) && b > 0) begin
      @(negedge clk);
      b--;
    end
    @(posedge clk); #1;
    chk("drain", (pend_q.size() == 0) && !in_flight, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic fib jobs; the first also sees the kernel's stale done at power-up.
    push_job(5, 0, 1, 6);
    wait_idle(100);
    chk("fib5_result", last_res, 5);
    chk("fib5_timeout", last_to, 0);
    chk("fib5_jobs_done", jobs_done, 1);
    push_job(10, 0, 1, 3);
    wait_idle(100);
    chk("fib10_result", last_res, 55);

    // Queue fill with the response stream stalled.
    rr_mode = 0;
    for (int i = 1; i <= 5; i++) push_job(6'(i), 0, 1, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fifo_full_ready", req_ready, 0);
    rr_mode = 1;
    push_job(6, 0, 1, 2);
    wait_idle(300);
    chk("fill_last_result", last_res, 8);
    chk("fill_jobs_done", jobs_done, 8);

    // Timeouts and the completion-vs-timeout boundary.
    push_job(7, 0, 1, 1000);
    wait_idle(100);
    chk("tmo_flag", last_to, 1);
    chk("tmo_result", last_res, 0);
    push_job(3, 0, 1, 15);
    wait_idle(100);
    chk("edge15_result", last_res, 2);
    push_job(3, 0, 1, 16);
    wait_idle(100);
    chk("edge16_timeout", last_to, 1);
    push_job(4, 0, 1, 2);
    wait_idle(100);
    chk("after_tmo_result", last_res, 3);

    // Response backpressure with another job waiting.
    rr_mode = 0;
    push_job(8, 0, 1, 2);
    push_job(9, 0, 1, 2);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_jobs_done", jobs_done, 12);
    chk("bp_valid_held", resp_valid, 1);
    rr_mode = 1;
    wait_idle(200);
    chk("bp_result", last_res, 34);
    chk("bp_jobs_done_after", jobs_done, 14);

    // Reset while a job is in WAIT with two more queued.
    push_job(11, 0, 1, 10);
    push_job(12, 0, 1, 10);
    push_job(13, 0, 1, 10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_kre", k_r_enable, 0);
    chk("arst_k_init_n", k_init_n, 0);
    chk("arst_k_init_a", k_init_a, 0);
    chk("arst_jobs_done", jobs_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    push_job(6, 0, 1, 3);
    wait_idle(100);
    chk("post_rst_result", last_res, 8);
    chk("post_rst_jobs_done", jobs_done, 1);

    // Randomized jobs, delays and response backpressure.
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      if (r < 7)       d = $urandom_range(1, 8);
      else if (r == 7) d = 15;
      else if (r == 8) d = 16;
      else             d = 40;
      push_job(6'($urandom_range(0, 24)), $urandom, $urandom, d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
      #0;
    end
    rr_mode = 1;
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
